// File: rtl/cmp_seq.sv
// Iterative wide-word magnitude comparator: walks 4-bit slices MSB first and
// continues the big/equal/small cascade from a seed supplied by a more-significant stage.
module cmp_seq #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             fi_big,
  input  logic             fi_equal,
  input  logic             fi_small,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fo_big,
  output logic             fo_equal,
  output logic             fo_small,
  output logic             busy
);

  localparam int SLICES = WIDTH / 4;
  localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;
  typedef enum logic [1:0] {R_EQ, R_BIG, R_SMALL} rel_t;

  state_t           state_reg;
  rel_t             rel_reg;
  rel_t             rel_next;
  rel_t             seed_rel;
  logic [KW-1:0]    k_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       fo_reg;
  logic             out_valid_reg;
  logic             in_ready_reg;
  logic             busy_reg;
  logic             cmp_finish;

  logic [3:0] a_slice [SLICES];
  logic [3:0] b_slice [SLICES];

  // Slice 0 is the most-significant nibble.
  for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
    assign a_slice[gi] = a_reg[WIDTH-1-4*gi -: 4];
    assign b_slice[gi] = b_reg[WIDTH-1-4*gi -: 4];
  end

  function automatic logic [2:0] rel_to_fo(input rel_t r);
    case (r)
      R_BIG:   rel_to_fo = 3'b100;
      R_SMALL: rel_to_fo = 3'b001;
      default: rel_to_fo = 3'b010;
    endcase
  endfunction

  // Conflicting seed flags resolve big first, then small; none set means equal.
  always_comb begin
    seed_rel = R_EQ;
    if (fi_big)
      seed_rel = R_BIG;
    else if (fi_small)
      seed_rel = R_SMALL;
  end

  always_comb begin
    rel_next = rel_reg;
    if (rel_reg == R_EQ) begin
      if (a_slice[k_reg] > b_slice[k_reg])
        rel_next = R_BIG;
      else if (a_slice[k_reg] < b_slice[k_reg])
        rel_next = R_SMALL;
    end
  end

  assign cmp_finish = (k_reg == K_LAST) || (EARLY_EXIT && (rel_next != R_EQ));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= S_IDLE;
      rel_reg       <= R_EQ;
      k_reg         <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      fo_reg        <= 3'b000;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            rel_reg      <= seed_rel;
            k_reg        <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            if (EARLY_EXIT && (seed_rel != R_EQ)) begin
              state_reg     <= S_DONE;
              out_valid_reg <= 1'b1;
              fo_reg        <= rel_to_fo(seed_rel);
            end else begin
              state_reg <= S_CMP;
            end
          end
        end
        S_CMP: begin
          rel_reg <= rel_next;
          if (cmp_finish) begin
            state_reg     <= S_DONE;
            out_valid_reg <= 1'b1;
            fo_reg        <= rel_to_fo(rel_next);
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign fo_big    = fo_reg[2];
  assign fo_equal  = fo_reg[1];
  assign fo_small  = fo_reg[0];

endmodule

// File: tb/tb_cmp_seq.sv
// Directed bench for cmp_seq: one instance per EARLY_EXIT setting, driven in lockstep.
module tb_cmp_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        fi_big = 1'b0, fi_equal = 1'b0, fi_small = 1'b0;

  logic in_ready1, out_valid1, fo_big1, fo_equal1, fo_small1, busy1;
  logic in_ready0, out_valid0, fo_big0, fo_equal0, fo_small0, busy0;
  logic [2:0] fo1, fo0;

  int checks = 0;
  int passed = 0;
  int acc1 = 0;
  int acc0 = 0;

  always #5 sys_clk = ~sys_clk;

  cmp_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_e1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .fi_big(fi_big), .fi_equal(fi_equal), .fi_small(fi_small),
    .out_valid(out_valid1), .out_ready(out_ready),
    .fo_big(fo_big1), .fo_equal(fo_equal1), .fo_small(fo_small1), .busy(busy1)
  );

  cmp_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_e0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .fi_big(fi_big), .fi_equal(fi_equal), .fi_small(fi_small),
    .out_valid(out_valid0), .out_ready(out_ready),
    .fo_big(fo_big0), .fo_equal(fo_equal0), .fo_small(fo_small0), .busy(busy0)
  );

  assign fo1 = {fo_big1, fo_equal1, fo_small1};
  assign fo0 = {fo_big0, fo_equal0, fo_small0};

  // Handshake monitor: counts accepted operations per instance.
  always @(posedge sys_clk) begin
    if (in_valid && in_ready1) acc1 <= acc1 + 1;
    if (in_valid && in_ready0) acc0 <= acc0 + 1;
  end

  // Issues one operation with out_ready=1 and measures accept-to-out_valid latency
  // (-1 when no result arrives within the budget) and the result flags.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic [2:0] tfi,
                        output int l1, output int l0,
                        output logic [2:0] f1, output logic [2:0] f0);
    l1 = -1; l0 = -1; f1 = 3'b000; f0 = 3'b000;
    @(negedge sys_clk);
    a = ta; b = tb; {fi_big, fi_equal, fi_small} = tfi; in_valid = 1'b1;
    @(negedge sys_clk);
    in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (out_valid1 && l1 < 0) begin l1 = n; f1 = fo1; end
      if (out_valid0 && l0 < 0) begin l0 = n; f0 = fo0; end
      if (l1 >= 0 && l0 >= 0) break;
      @(negedge sys_clk);
    end
    $display("op a=%h b=%h fi=%b : e1 lat=%0d fo=%b | e0 lat=%0d fo=%b", ta, tb, tfi, l1, f1, l0, f0);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({in_ready1, out_valid1, fo1, busy1} !== 6'b100000)
      $display("FAIL reset_e1 got %b want 100000", {in_ready1, out_valid1, fo1, busy1});
    else passed++;
    checks++;
    if ({in_ready0, out_valid0, fo0, busy0} !== 6'b100000)
      $display("FAIL reset_e0 got %b want 100000", {in_ready0, out_valid0, fo0, busy0});
    else passed++;
  endtask

  task automatic test_equal();
    int l1, l0; logic [2:0] f1, f0;
    run_op(16'h1234, 16'h1234, 3'b010, l1, l0, f1, f0);
    checks++; if (l1 !== 5) $display("FAIL equal_lat_e1 got %0d want 5", l1); else passed++;
    checks++; if (l0 !== 5) $display("FAIL equal_lat_e0 got %0d want 5", l0); else passed++;
    checks++; if (f1 !== 3'b010) $display("FAIL equal_fo_e1 got %b want 010", f1); else passed++;
    checks++; if (f0 !== 3'b010) $display("FAIL equal_fo_e0 got %b want 010", f0); else passed++;
  endtask

  task automatic test_msb_decides();
    int l1, l0; logic [2:0] f1, f0;
    run_op(16'h8000, 16'h7FFF, 3'b010, l1, l0, f1, f0);
    checks++; if (l1 !== 2) $display("FAIL msb_lat_e1 got %0d want 2", l1); else passed++;
    checks++; if (l0 !== 5) $display("FAIL msb_lat_e0 got %0d want 5", l0); else passed++;
    checks++; if (f1 !== 3'b100) $display("FAIL msb_fo_e1 got %b want 100", f1); else passed++;
    checks++; if (f0 !== 3'b100) $display("FAIL msb_fo_e0 got %b want 100", f0); else passed++;
    // Second slice decides: d=1 gives latency 3 with early exit.
    run_op(16'h0300, 16'h0400, 3'b010, l1, l0, f1, f0);
    checks++; if (l1 !== 3) $display("FAIL mid_lat_e1 got %0d want 3", l1); else passed++;
    checks++; if (f0 !== 3'b001) $display("FAIL mid_fo_e0 got %b want 001", f0); else passed++;
  endtask

  task automatic test_lsb_decides();
    int l1, l0; logic [2:0] f1, f0;
    run_op(16'h00A5, 16'h00A6, 3'b010, l1, l0, f1, f0);
    checks++; if (l1 !== 5) $display("FAIL lsb_lat_e1 got %0d want 5", l1); else passed++;
    checks++; if (l0 !== 5) $display("FAIL lsb_lat_e0 got %0d want 5", l0); else passed++;
    checks++; if (f1 !== 3'b001) $display("FAIL lsb_fo_e1 got %b want 001", f1); else passed++;
    checks++; if (f0 !== 3'b001) $display("FAIL lsb_fo_e0 got %b want 001", f0); else passed++;
  endtask

  task automatic test_seed();
    int l1, l0; logic [2:0] f1, f0;
    run_op(16'hFFFF, 16'h0000, 3'b001, l1, l0, f1, f0);
    checks++; if (l1 !== 1) $display("FAIL seed_small_lat_e1 got %0d want 1", l1); else passed++;
    checks++; if (l0 !== 5) $display("FAIL seed_small_lat_e0 got %0d want 5", l0); else passed++;
    checks++; if (f1 !== 3'b001) $display("FAIL seed_small_fo_e1 got %b want 001", f1); else passed++;
    checks++; if (f0 !== 3'b001) $display("FAIL seed_small_fo_e0 got %b want 001", f0); else passed++;
    run_op(16'h0000, 16'hFFFF, 3'b101, l1, l0, f1, f0);
    checks++; if (l1 !== 1) $display("FAIL seed_both_lat_e1 got %0d want 1", l1); else passed++;
    checks++; if (f1 !== 3'b100) $display("FAIL seed_both_fo_e1 got %b want 100", f1); else passed++;
    checks++; if (f0 !== 3'b100) $display("FAIL seed_both_fo_e0 got %b want 100", f0); else passed++;
    run_op(16'h5A5A, 16'h5A5A, 3'b000, l1, l0, f1, f0);
    checks++; if (l1 !== 5) $display("FAIL seed_none_lat_e1 got %0d want 5", l1); else passed++;
    checks++; if (f1 !== 3'b010) $display("FAIL seed_none_fo_e1 got %b want 010", f1); else passed++;
    checks++; if (f0 !== 3'b010) $display("FAIL seed_none_fo_e0 got %b want 010", f0); else passed++;
  endtask

  task automatic test_back_to_back();
    bit found;
    int base1, base0;
    base1 = acc1; base0 = acc0;
    @(negedge sys_clk);
    out_ready = 1'b0;
    a = 16'h1234; b = 16'h1234; {fi_big, fi_equal, fi_small} = 3'b010; in_valid = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge sys_clk);
      if (out_valid1 && out_valid0) begin found = 1'b1; break; end
    end
    checks++; if (!found) $display("FAIL bp_result_timeout got none want out_valid"); else passed++;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge sys_clk);
      checks++;
      if ({out_valid1, fo1, in_ready1, out_valid0, fo0, in_ready0} !== 10'b1_010_0_1_010_0)
        $display("FAIL bp_hold%0d got %b want 1010010100", i,
                 {out_valid1, fo1, in_ready1, out_valid0, fo0, in_ready0});
      else passed++;
    end
    checks++;
    if ((acc1 - base1) !== 1 || (acc0 - base0) !== 1)
      $display("FAIL bp_accepts got %0d/%0d want 1/1", acc1 - base1, acc0 - base0);
    else passed++;
    out_ready = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({out_valid1, in_ready1, out_valid0, in_ready0} !== 4'b0101)
      $display("FAIL bp_release got %b want 0101", {out_valid1, in_ready1, out_valid0, in_ready0});
    else passed++;
    @(negedge sys_clk);
    checks++;
    if ((acc1 - base1) !== 2 || (acc0 - base0) !== 2 || in_ready1 !== 1'b0)
      $display("FAIL bp_reaccept got %0d/%0d in_ready=%b want 2/2 in_ready=0",
               acc1 - base1, acc0 - base0, in_ready1);
    else passed++;
    in_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid1 && out_valid0) begin found = 1'b1; break; end
      @(negedge sys_clk);
    end
    checks++;
    if (!found || fo1 !== 3'b010 || fo0 !== 3'b010)
      $display("FAIL bp_drain got found=%b fo=%b/%b want found=1 fo=010/010", found, fo1, fo0);
    else passed++;
    $display("op back_to_back accepts e1=%0d e0=%0d", acc1 - base1, acc0 - base0);
  endtask

  task automatic test_reset_mid();
    int l1, l0; logic [2:0] f1, f0;
    @(negedge sys_clk);
    a = 16'h1234; b = 16'h1234; {fi_big, fi_equal, fi_small} = 3'b010; in_valid = 1'b1;
    @(negedge sys_clk);
    in_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({busy1, busy0, out_valid1} !== 3'b110)
      $display("FAIL rst_mid_pre got %b want 110", {busy1, busy0, out_valid1});
    else passed++;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid1, fo1, busy1, in_ready1, out_valid0, fo0, busy0, in_ready0} !== 12'b0000_0_1_0000_0_1)
      $display("FAIL rst_mid_async got %b want 000001000001",
               {out_valid1, fo1, busy1, in_ready1, out_valid0, fo0, busy0, in_ready0});
    else passed++;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({in_ready1, in_ready0, out_valid1, out_valid0} !== 4'b1100)
      $display("FAIL rst_mid_release got %b want 1100", {in_ready1, in_ready0, out_valid1, out_valid0});
    else passed++;
    run_op(16'h8000, 16'h7FFF, 3'b010, l1, l0, f1, f0);
    checks++; if (l1 !== 2) $display("FAIL rst_after_lat_e1 got %0d want 2", l1); else passed++;
    checks++; if (l0 !== 5) $display("FAIL rst_after_lat_e0 got %0d want 5", l0); else passed++;
    checks++; if (f1 !== 3'b100) $display("FAIL rst_after_fo_e1 got %b want 100", f1); else passed++;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_msb_decides();
    test_lsb_decides();
    test_seed();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
